sync_fifo_flex: RTL and testbench

//  Single-clock, parametrised successor to the dual-clock FIFO top.
//  - Any depth >= 2 (not restricted to a power of two).
//  - Outputs: occupancy count, almost-full/almost-empty thresholds, sticky overflow/underflow error flags.
//  - Used as the rate-matching buffer inside one clock domain, between datapath stages.

---
 rtl/sync_fifo_flex_pkg.sv | 34 +++
 rtl/sync_fifo_flex_if.sv | 34 +++
 rtl/sync_fifo_mem.sv | 26 ++
 rtl/sync_fifo_flex.sv | 128 ++++++++++++
 tb/tb_sync_fifo_flex.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sync_fifo_flex_pkg.sv
// Shared definitions for sync_fifo_flex: width helpers, flag bundle and
// reset values used by the top and its memory sub-block.
package fifo_pkg;

    // Occupancy counter width: must hold 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Pointer width: indexes 0..depth-1, at least one bit.
    function automatic int ptr_w(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

    // Occupancy-derived status flags, registered together with COUNT.
    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

    localparam fifo_flags_t FLAGS_RST = '{
        full:         1'b0,
        empty:        1'b1,
        almost_full:  1'b0,
        almost_empty: 1'b1
    };

    localparam logic OVERFLOW_RST  = 1'b0;
    localparam logic UNDERFLOW_RST = 1'b0;
    localparam logic RD_VALID_RST  = 1'b0;

endpackage

// File: rtl/sync_fifo_flex_if.sv
// Handshake/status bundle between a producer/consumer and sync_fifo_flex.
// master: the datapath stage driving requests; slave: the FIFO itself.
interface sync_fifo_flex_if #(
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 16
) ();
    import fifo_pkg::*;

    logic                            W_INC;
    logic [DATA_WIDTH-1:0]           WR_DATA;
    logic                            R_INC;
    logic [DATA_WIDTH-1:0]           RD_DATA;
    logic                            RD_VALID;
    logic                            FULL;
    logic                            EMPTY;
    logic                            ALMOST_FULL;
    logic                            ALMOST_EMPTY;
    logic [cnt_w(MEM_DEPTH)-1:0]     COUNT;
    logic                            OVERFLOW;
    logic                            UNDERFLOW;

    modport master (
        output W_INC, WR_DATA, R_INC,
        input  RD_DATA, RD_VALID, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY,
               COUNT, OVERFLOW, UNDERFLOW
    );

    modport slave (
        input  W_INC, WR_DATA, R_INC,
        output RD_DATA, RD_VALID, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY,
               COUNT, OVERFLOW, UNDERFLOW
    );

endinterface

// File: rtl/sync_fifo_mem.sv
// Storage array for sync_fifo_flex: one clocked write port, one
// asynchronous read port. Contents are never reset.
module sync_fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 16
) (
    input  logic                                   clk,
    input  logic                                   wr_en,
    input  logic [fifo_pkg::ptr_w(MEM_DEPTH)-1:0]  wr_ptr,
    input  logic [DATA_WIDTH-1:0]                  wr_data,
    input  logic [fifo_pkg::ptr_w(MEM_DEPTH)-1:0]  rd_ptr,
    output logic [DATA_WIDTH-1:0]                  rd_data
);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Write the accepted word at the write pointer.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with arbitrary depth (>= 2), occupancy count,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
// Read mode: define SYNC_FIFO_FWFT_EN for first-word-fall-through,
// otherwise RD_DATA is registered on each pop.
module sync_fifo_flex #(
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 16,
    parameter int AF_LEVEL   = MEM_DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic              CLK,
    input  logic              RST,
    sync_fifo_flex_if.slave   fifo
);
    import fifo_pkg::*;

    localparam int PW = ptr_w(MEM_DEPTH);
    localparam int CW = cnt_w(MEM_DEPTH);

    localparam logic [PW-1:0] PTR_LAST = PW'(MEM_DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(MEM_DEPTH);
    localparam logic [CW-1:0] CNT_AF   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] CNT_AE   = CW'(AE_LEVEL);

    logic [PW-1:0]         w_ptr_q, w_ptr_nxt;
    logic [PW-1:0]         r_ptr_q, r_ptr_nxt;
    logic [CW-1:0]         count_q, count_nxt;
    fifo_flags_t           flags_q, flags_nxt;
    logic                  overflow_q, underflow_q;
    logic                  wr_acc, rd_acc;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    // Accept decisions, next pointers, next count and flags derived from it.
    always_comb begin
        wr_acc    = fifo.W_INC & ~flags_q.full;
        rd_acc    = fifo.R_INC & ~flags_q.empty;
        count_nxt = count_q + CW'(wr_acc) - CW'(rd_acc);

        w_ptr_nxt = w_ptr_q;
        if (wr_acc) begin
            w_ptr_nxt = (w_ptr_q == PTR_LAST) ? '0 : w_ptr_q + PW'(1);
        end

        r_ptr_nxt = r_ptr_q;
        if (rd_acc) begin
            r_ptr_nxt = (r_ptr_q == PTR_LAST) ? '0 : r_ptr_q + PW'(1);
        end

        flags_nxt              = FLAGS_RST;
        flags_nxt.full         = (count_nxt == CNT_FULL);
        flags_nxt.empty        = (count_nxt == '0);
        flags_nxt.almost_full  = (count_nxt >= CNT_AF);
        flags_nxt.almost_empty = (count_nxt <= CNT_AE);
    end

    // Pointer, occupancy and flag registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            count_q <= '0;
            flags_q <= FLAGS_RST;
        end else begin
            w_ptr_q <= w_ptr_nxt;
            r_ptr_q <= r_ptr_nxt;
            count_q <= count_nxt;
            flags_q <= flags_nxt;
        end
    end

    // Sticky error flags: latch any request rejected by FULL/EMPTY.
    always_ff @(posedge CLK) begin
        if (RST) begin
            overflow_q  <= OVERFLOW_RST;
            underflow_q <= UNDERFLOW_RST;
        end else begin
            overflow_q  <= overflow_q  | (fifo.W_INC & flags_q.full);
            underflow_q <= underflow_q | (fifo.R_INC & flags_q.empty);
        end
    end

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_mem (
        .clk     (CLK),
        .wr_en   (wr_acc),
        .wr_ptr  (w_ptr_q),
        .wr_data (fifo.WR_DATA),
        .rd_ptr  (r_ptr_q),
        .rd_data (mem_rd_data)
    );

`ifdef SYNC_FIFO_FWFT_EN
    // Head word shown directly; forced to zero while empty so that stale,
    // never-cleared memory contents are not presented after reset.
    assign fifo.RD_DATA  = flags_q.empty ? '0 : mem_rd_data;
    assign fifo.RD_VALID = ~flags_q.empty;
`else
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    // Capture the popped word; RD_VALID pulses for one cycle per pop.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_data_q  <= '0;
            rd_valid_q <= RD_VALID_RST;
        end else begin
            rd_valid_q <= rd_acc;
            if (rd_acc) begin
                rd_data_q <= mem_rd_data;
            end
        end
    end

    assign fifo.RD_DATA  = rd_data_q;
    assign fifo.RD_VALID = rd_valid_q;
`endif

    assign fifo.FULL         = flags_q.full;
    assign fifo.EMPTY        = flags_q.empty;
    assign fifo.ALMOST_FULL  = flags_q.almost_full;
    assign fifo.ALMOST_EMPTY = flags_q.almost_empty;
    assign fifo.COUNT        = count_q;
    assign fifo.OVERFLOW     = overflow_q;
    assign fifo.UNDERFLOW    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Testbench for sync_fifo_flex: a 16-deep instance with default thresholds
// and a 5-deep instance (AF_LEVEL=3, AE_LEVEL=1). Read data is checked by
// per-instance monitors against expected-word queues filled by the stimulus.
module tb_sync_fifo_flex;

    logic CLK = 1'b0;
    logic rst_a;
    logic rst_b;
    int   total = 0;
    int   bad   = 0;

    logic [7:0] qa[$];
    logic [7:0] qb[$];

    always #5 CLK = ~CLK;

    sync_fifo_flex_if #(.DATA_WIDTH(8), .MEM_DEPTH(16)) if_a ();
    sync_fifo_flex_if #(.DATA_WIDTH(8), .MEM_DEPTH(5))  if_b ();

    sync_fifo_flex #(
        .DATA_WIDTH (8),
        .MEM_DEPTH  (16)
    ) dut_a (
        .CLK  (CLK),
        .RST  (rst_a),
        .fifo (if_a.slave)
    );

    sync_fifo_flex #(
        .DATA_WIDTH (8),
        .MEM_DEPTH  (5),
        .AF_LEVEL   (3),
        .AE_LEVEL   (1)
    ) dut_b (
        .CLK  (CLK),
        .RST  (rst_b),
        .fifo (if_b.slave)
    );

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     nm, act, act, exp, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // A word is delivered when the monitor sees it consumed.
    logic fire_a, fire_b;
`ifdef SYNC_FIFO_FWFT_EN
    assign fire_a = if_a.RD_VALID & if_a.R_INC & ~rst_a;
    assign fire_b = if_b.RD_VALID & if_b.R_INC & ~rst_b;
`else
    assign fire_a = if_a.RD_VALID;
    assign fire_b = if_b.RD_VALID;
`endif

    // Monitor for the 16-deep instance.
    always @(negedge CLK) begin
        if (fire_a === 1'b1) begin
            if (qa.size() == 0) chk("a_rd_extra", int'(if_a.RD_DATA), -1);
            else                chk("a_rd_data", int'(if_a.RD_DATA), int'(qa.pop_front()));
        end
    end

    // Monitor for the 5-deep instance.
    always @(negedge CLK) begin
        if (fire_b === 1'b1) begin
            if (qb.size() == 0) chk("b_rd_extra", int'(if_b.RD_DATA), -1);
            else                chk("b_rd_data", int'(if_b.RD_DATA), int'(qb.pop_front()));
        end
    end

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        if_a.W_INC = 1'b0; if_a.R_INC = 1'b0; if_a.WR_DATA = '0;
        if_b.W_INC = 1'b0; if_b.R_INC = 1'b0; if_b.WR_DATA = '0;
        step();
        step();
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Reset state
        chk("a_rst_count", int'(if_a.COUNT), 0);
        chk("a_rst_empty", int'(if_a.EMPTY), 1);
        chk("a_rst_ae", int'(if_a.ALMOST_EMPTY), 1);
        chk("a_rst_full", int'(if_a.FULL), 0);
        chk("a_rst_af", int'(if_a.ALMOST_FULL), 0);
        chk("a_rst_ovf", int'(if_a.OVERFLOW), 0);
        chk("a_rst_unf", int'(if_a.UNDERFLOW), 0);
        chk("a_rst_rdv", int'(if_a.RD_VALID), 0);
        chk("a_rst_rdd", int'(if_a.RD_DATA), 0);
        chk("b_rst_count", int'(if_b.COUNT), 0);
        chk("b_rst_empty", int'(if_b.EMPTY), 1);

        // 1: fill with 0x01..0x10
        for (int i = 1; i <= 16; i++) begin
            if_a.W_INC = 1'b1;
            if_a.WR_DATA = 8'(i);
            qa.push_back(8'(i));
            step();
            chk("t1_count", int'(if_a.COUNT), i);
            chk("t1_af", int'(if_a.ALMOST_FULL), (i >= 14) ? 1 : 0);
            chk("t1_full", int'(if_a.FULL), (i == 16) ? 1 : 0);
            chk("t1_empty", int'(if_a.EMPTY), 0);
            chk("t1_ovf", int'(if_a.OVERFLOW), 0);
        end

        // 2: write while full is rejected and sets OVERFLOW
        if_a.WR_DATA = 8'hAA;
        step();
        chk("t2_ovf", int'(if_a.OVERFLOW), 1);
        chk("t2_count", int'(if_a.COUNT), 16);
        chk("t2_full", int'(if_a.FULL), 1);
        if_a.W_INC = 1'b0;
        step();
        chk("t2_ovf_sticky", int'(if_a.OVERFLOW), 1);

        // 3: simultaneous write/read while full pops 0x01, write rejected
        if_a.W_INC = 1'b1;
        if_a.R_INC = 1'b1;
        if_a.WR_DATA = 8'hBB;
        step();
        chk("t3_count", int'(if_a.COUNT), 15);
        chk("t3_full", int'(if_a.FULL), 0);
        chk("t3_ovf", int'(if_a.OVERFLOW), 1);
        if_a.W_INC = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            step();
            chk("t3_drain_count", int'(if_a.COUNT), 15 - k);
            chk("t3_drain_empty", int'(if_a.EMPTY), (k == 15) ? 1 : 0);
            chk("t3_drain_ae", int'(if_a.ALMOST_EMPTY), ((15 - k) <= 2) ? 1 : 0);
        end
        if_a.R_INC = 1'b0;
        step();
        chk("t3_unf_clear", int'(if_a.UNDERFLOW), 0);

        // 5: read while empty sets UNDERFLOW, then a single word 0x5A
        if_a.R_INC = 1'b1;
        step();
        chk("t5_unf", int'(if_a.UNDERFLOW), 1);
        chk("t5_count", int'(if_a.COUNT), 0);
        chk("t5_rdv", int'(if_a.RD_VALID), 0);
        if_a.R_INC = 1'b0;
        if_a.W_INC = 1'b1;
        if_a.WR_DATA = 8'h5A;
        qa.push_back(8'h5A);
        step();
        chk("t5_empty_deassert", int'(if_a.EMPTY), 0);
`ifdef SYNC_FIFO_FWFT_EN
        chk("t5_fwft_rdv", int'(if_a.RD_VALID), 1);
        chk("t5_fwft_rdd", int'(if_a.RD_DATA), 8'h5A);
        if_a.W_INC = 1'b0;
        if_a.R_INC = 1'b1;
        step();
        if_a.R_INC = 1'b0;
        chk("t5_fwft_empty", int'(if_a.EMPTY), 1);
        chk("t5_fwft_rdv_off", int'(if_a.RD_VALID), 0);
`else
        if_a.W_INC = 1'b0;
        if_a.R_INC = 1'b1;
        step();
        if_a.R_INC = 1'b0;
        chk("t5_std_rdv", int'(if_a.RD_VALID), 1);
        chk("t5_std_rdd", int'(if_a.RD_DATA), 8'h5A);
        step();
        chk("t5_std_rdv_pulse", int'(if_a.RD_VALID), 0);
        chk("t5_std_rdd_hold", int'(if_a.RD_DATA), 8'h5A);
`endif
        chk("t5_unf_sticky", int'(if_a.UNDERFLOW), 1);

        // 6: fill to 8, steady write+read, then reset mid-stream
        for (int i = 0; i < 8; i++) begin
            if_a.W_INC = 1'b1;
            if_a.WR_DATA = 8'(8'h21 + i);
            qa.push_back(8'(8'h21 + i));
            step();
        end
        chk("t6_fill_count", int'(if_a.COUNT), 8);
        for (int i = 0; i < 4; i++) begin
            if_a.W_INC = 1'b1;
            if_a.R_INC = 1'b1;
            if_a.WR_DATA = 8'(8'h31 + i);
            qa.push_back(8'(8'h31 + i));
            step();
            chk("t6_steady_count", int'(if_a.COUNT), 8);
        end
        rst_a = 1'b1;
        if_a.WR_DATA = 8'h35;
        step();
        chk("t6_rst_count", int'(if_a.COUNT), 0);
        chk("t6_rst_empty", int'(if_a.EMPTY), 1);
        chk("t6_rst_ovf", int'(if_a.OVERFLOW), 0);
        chk("t6_rst_unf", int'(if_a.UNDERFLOW), 0);
        chk("t6_rst_rdd", int'(if_a.RD_DATA), 0);
        chk("t6_rst_rdv", int'(if_a.RD_VALID), 0);
        qa.delete();
        rst_a = 1'b0;
        if_a.W_INC = 1'b0;
        if_a.R_INC = 1'b0;
        step();
        chk("t6_post_count", int'(if_a.COUNT), 0);

        // 4: depth 5; one-word offset so pointers wrap 4->0 mid-round
        if_b.W_INC = 1'b1;
        if_b.WR_DATA = 8'h0F;
        qb.push_back(8'h0F);
        step();
        if_b.W_INC = 1'b0;
        if_b.R_INC = 1'b1;
        step();
        if_b.R_INC = 1'b0;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 5; i++) begin
                if_b.W_INC = 1'b1;
                if_b.WR_DATA = 8'(8'h40 + r * 8 + i);
                qb.push_back(8'(8'h40 + r * 8 + i));
                step();
                chk("t4_wr_count", int'(if_b.COUNT), i + 1);
                chk("t4_wr_full", int'(if_b.FULL), (i == 4) ? 1 : 0);
                chk("t4_wr_af", int'(if_b.ALMOST_FULL), ((i + 1) >= 3) ? 1 : 0);
            end
            if_b.W_INC = 1'b0;
            for (int i = 0; i < 5; i++) begin
                if_b.R_INC = 1'b1;
                step();
                chk("t4_rd_count", int'(if_b.COUNT), 4 - i);
                chk("t4_rd_empty", int'(if_b.EMPTY), (i == 4) ? 1 : 0);
                chk("t4_rd_ae", int'(if_b.ALMOST_EMPTY), ((4 - i) <= 1) ? 1 : 0);
            end
            if_b.R_INC = 1'b0;
            step();
        end
        chk("t4_ovf", int'(if_b.OVERFLOW), 0);
        chk("t4_unf", int'(if_b.UNDERFLOW), 0);

        step();
        step();
        chk("a_words_left", qa.size(), 0);
        chk("b_words_left", qb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
